// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode trap types: sequencer states, exception flag bundle and cause codes.
package machine_mode_types_1_12_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT,
    SLEEP
  } prv_trap_state_t;

  localparam logic [3:0] CAUSE_INSN_MAL    = 4'd0;
  localparam logic [3:0] CAUSE_INSN_FAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MAL    = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MAL   = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_ENV_M       = 4'd11;
  localparam logic [3:0] IRQ_SOFT          = 4'd3;
  localparam logic [3:0] IRQ_TIMER         = 4'd7;
  localparam logic [3:0] IRQ_EXT           = 4'd11;

  typedef struct packed {
    logic fault_insn;
    logic mal_insn;
    logic illegal_insn;
    logic breakpoint;
    logic env;
    logic mal_s;
    logic mal_l;
    logic fault_s;
    logic fault_l;
  } prv_exc_t;

  typedef struct packed {
    logic       valid;
    logic       intr;
    logic [3:0] code;
  } prv_cause_t;

endpackage

// File: rtl/prv_cause_encoder.sv
// Priority encoder: picks the single winning exception, else the highest enabled interrupt.
module prv_cause_encoder
  import machine_mode_types_1_12_pkg::*;
(
  input  prv_exc_t   exc,
  input  logic       irq_take,
  input  logic [2:0] irq_pend,   // {ext,soft,timer} already masked by mie_bits
  output prv_cause_t cause
);

  always_comb begin
    cause = '0;
    cause.valid = 1'b1;
    if      (exc.fault_insn)   cause.code = CAUSE_INSN_FAULT;
    else if (exc.mal_insn)     cause.code = CAUSE_INSN_MAL;
    else if (exc.illegal_insn) cause.code = CAUSE_ILLEGAL;
    else if (exc.breakpoint)   cause.code = CAUSE_BREAKPOINT;
    else if (exc.env)          cause.code = CAUSE_ENV_M;
    else if (exc.mal_s)        cause.code = CAUSE_STORE_MAL;
    else if (exc.mal_l)        cause.code = CAUSE_LOAD_MAL;
    else if (exc.fault_s)      cause.code = CAUSE_STORE_FAULT;
    else if (exc.fault_l)      cause.code = CAUSE_LOAD_FAULT;
    else if (irq_take) begin
      cause.intr = 1'b1;
      if      (irq_pend[2]) cause.code = IRQ_EXT;
      else if (irq_pend[1]) cause.code = IRQ_SOFT;
      else                  cause.code = IRQ_TIMER;
    end else begin
      cause.valid = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap/MRET/WFI sequencer: select event, drain pipeline, commit CSRs, redirect fetch.
module prv_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int DRAIN_MAX = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              fault_insn,
  input  logic              mal_insn,
  input  logic              illegal_insn,
  input  logic              breakpoint,
  input  logic              env,
  input  logic              mal_s,
  input  logic              mal_l,
  input  logic              fault_s,
  input  logic              fault_l,
  input  logic              ret,
  input  logic              wfi,
  input  logic              pipe_clear,
  input  logic [WORD_W-1:0] epc,
  input  logic [WORD_W-1:0] badaddr,
  input  logic              ext_int,
  input  logic              soft_int,
  input  logic              timer_int,
  input  logic [2:0]        mie_bits,
  input  logic              mstatus_mie,
  input  logic [WORD_W-1:0] mtvec,
  input  logic [WORD_W-1:0] mepc,
  output logic [WORD_W-1:0] priv_pc,
  output logic              insert_pc,
  output logic              intr,
  output logic              trap_we,
  output logic              ret_we,
  output logic [WORD_W-1:0] mcause_o,
  output logic [WORD_W-1:0] mepc_o,
  output logic [WORD_W-1:0] mtval_o,
  output logic              wfi_stall,
  output logic              drain_timeout
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  prv_trap_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic              intr_q, intr_d;
  logic              is_ret_q, is_ret_d;
  logic [WORD_W-1:0] epc_q, epc_d;
  logic [WORD_W-1:0] tval_q, tval_d;
  logic              timeout_q, timeout_d;

  logic [2:0]        irq_pend;
  logic              irq_take;
  prv_exc_t          exc;
  prv_cause_t        cause;
  logic [WORD_W-1:0] tvec_base;

  assign irq_pend  = {ext_int, soft_int, timer_int} & mie_bits;
  assign irq_take  = mstatus_mie & (|irq_pend);
  assign exc       = '{fault_insn, mal_insn, illegal_insn, breakpoint, env,
                       mal_s, mal_l, fault_s, fault_l};
  assign tvec_base = {mtvec[WORD_W-1:2], 2'b00};

  prv_cause_encoder u_enc (
    .exc      (exc),
    .irq_take (irq_take),
    .irq_pend (irq_pend),
    .cause    (cause)
  );

  assign mcause_o      = {intr_q, {(WORD_W-5){1'b0}}, code_q};
  assign mepc_o        = epc_q;
  assign mtval_o       = tval_q;
  assign drain_timeout = timeout_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    intr_d    = intr_q;
    is_ret_d  = is_ret_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    timeout_d = timeout_q;
    trap_we   = 1'b0;
    ret_we    = 1'b0;
    insert_pc = 1'b0;
    intr      = 1'b0;
    priv_pc   = '0;
    wfi_stall = 1'b0;
    case (state_q)
      IDLE: begin
        // Exceptions beat MRET, which beats interrupts; the encoder already ranks exc over irq.
        if (cause.valid && !cause.intr) begin
          code_d   = cause.code;
          intr_d   = 1'b0;
          is_ret_d = 1'b0;
          epc_d    = epc;
          tval_d   = badaddr;
          state_d  = DRAIN;
        end else if (ret) begin
          code_d   = '0;
          intr_d   = 1'b0;
          is_ret_d = 1'b1;
          state_d  = DRAIN;
        end else if (cause.valid) begin
          code_d   = cause.code;
          intr_d   = 1'b1;
          is_ret_d = 1'b0;
          epc_d    = epc;
          tval_d   = '0;
          state_d  = DRAIN;
        end else if (wfi && !(|irq_pend)) begin
          state_d  = SLEEP;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (pipe_clear) begin
          state_d = COMMIT;
        end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
          timeout_d = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        trap_we = !is_ret_q;
        ret_we  = is_ret_q;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        insert_pc = 1'b1;
        intr      = intr_q;
        if (is_ret_q)                       priv_pc = mepc;
        else if (intr_q && mtvec[1:0] == 2'b01) priv_pc = tvec_base + {{(WORD_W-6){1'b0}}, code_q, 2'b00};
        else                                priv_pc = tvec_base;
        cnt_d   = '0;
        state_d = IDLE;
      end
      SLEEP: begin
        // Wake ignores mstatus_mie; IDLE decides whether a trap follows.
        wfi_stall = 1'b1;
        if (|irq_pend) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      intr_q    <= 1'b0;
      is_ret_q  <= 1'b0;
      epc_q     <= '0;
      tval_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      intr_q    <= intr_d;
      is_ret_q  <= is_ret_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Directed bench for prv_trap_sequencer with hand-computed expectations.
module tb_prv_trap_sequencer;

  logic        clk, nrst;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env;
  logic        mal_s, mal_l, fault_s, fault_l, ret, wfi, pipe_clear;
  logic [31:0] epc, badaddr, mtvec, mepc;
  logic        ext_int, soft_int, timer_int, mstatus_mie;
  logic [2:0]  mie_bits;
  logic [31:0] priv_pc, mcause_o, mepc_o, mtval_o;
  logic        insert_pc, intr, trap_we, ret_we, wfi_stall, drain_timeout;

  int n_chk = 0;
  int n_err = 0;

  prv_trap_sequencer #(.WORD_W(32), .DRAIN_MAX(16)) dut (
    .CLK(clk), .nRST(nrst),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env(env), .mal_s(mal_s), .mal_l(mal_l),
    .fault_s(fault_s), .fault_l(fault_l), .ret(ret), .wfi(wfi),
    .pipe_clear(pipe_clear), .epc(epc), .badaddr(badaddr),
    .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
    .mie_bits(mie_bits), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc(mepc),
    .priv_pc(priv_pc), .insert_pc(insert_pc), .intr(intr), .trap_we(trap_we),
    .ret_we(ret_we), .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o),
    .wfi_stall(wfi_stall), .drain_timeout(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_events();
    {fault_insn, mal_insn, illegal_insn, breakpoint, env} = '0;
    {mal_s, mal_l, fault_s, fault_l, ret, wfi} = '0;
    {ext_int, soft_int, timer_int} = '0;
  endtask

  // Event already applied; walks DRAIN -> COMMIT -> REDIRECT with pipe_clear high.
  task automatic do_trap(input string tag, input logic [31:0] cause, input logic [31:0] pc_e,
                         input logic [31:0] tval, input logic [31:0] tgt, input logic intr_e);
    tick();
    chk({tag, ".drain_we"}, {31'd0, trap_we}, 32'd0);
    tick();
    chk({tag, ".trap_we"}, {31'd0, trap_we}, 32'd1);
    chk({tag, ".ret_we"}, {31'd0, ret_we}, 32'd0);
    chk({tag, ".mcause"}, mcause_o, cause);
    chk({tag, ".mepc"}, mepc_o, pc_e);
    chk({tag, ".mtval"}, mtval_o, tval);
    chk({tag, ".early_ins"}, {31'd0, insert_pc}, 32'd0);
    tick();
    chk({tag, ".insert_pc"}, {31'd0, insert_pc}, 32'd1);
    chk({tag, ".priv_pc"}, priv_pc, tgt);
    chk({tag, ".intr"}, {31'd0, intr}, {31'd0, intr_e});
    chk({tag, ".we_once"}, {31'd0, trap_we}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    clr_events();
    pipe_clear = 1'b1; epc = '0; badaddr = '0; mtvec = 32'h100; mepc = '0;
    mie_bits = '0; mstatus_mie = 1'b0;
    #22;
    chk("rst.insert_pc", {31'd0, insert_pc}, 32'd0);
    chk("rst.trap_we", {31'd0, trap_we}, 32'd0);
    chk("rst.mcause", mcause_o, 32'd0);
    chk("rst.priv_pc", priv_pc, 32'd0);
    chk("rst.wfi_stall", {31'd0, wfi_stall}, 32'd0);
    chk("rst.timeout", {31'd0, drain_timeout}, 32'd0);
    nrst = 1'b1;
    tick();

    // Case 1: illegal instruction, direct vector
    illegal_insn = 1'b1; epc = 32'h200; badaddr = 32'h13;
    do_trap("c1", 32'd2, 32'h200, 32'h13, 32'h100, 1'b0);
    clr_events(); tick();

    // Case 2: vectored timer interrupt
    mtvec = 32'h101; mstatus_mie = 1'b1; mie_bits = 3'b111; timer_int = 1'b1;
    epc = 32'h204; badaddr = 32'h55;
    do_trap("c2", 32'h8000_0007, 32'h204, 32'h0, 32'h11C, 1'b1);
    clr_events(); tick();

    // Case 3: fault_l + mal_insn + ext_int together; exception first, irq afterwards
    mtvec = 32'h100; epc = 32'h300; badaddr = 32'h77;
    fault_l = 1'b1; mal_insn = 1'b1; ext_int = 1'b1;
    do_trap("c3a", 32'd0, 32'h300, 32'h77, 32'h100, 1'b0);
    fault_l = 1'b0; mal_insn = 1'b0;
    tick();
    do_trap("c3b", 32'h8000_000B, 32'h300, 32'h0, 32'h100, 1'b1);
    clr_events(); tick();

    // Priority among lower exceptions: env over mal_s, mal_l over fault_s
    env = 1'b1; mal_s = 1'b1; epc = 32'h310; badaddr = 32'h1;
    do_trap("pri_env", 32'd11, 32'h310, 32'h1, 32'h100, 1'b0);
    clr_events(); tick();
    mal_l = 1'b1; fault_s = 1'b1; epc = 32'h320; badaddr = 32'h2;
    do_trap("pri_mall", 32'd4, 32'h320, 32'h2, 32'h100, 1'b0);
    clr_events(); tick();

    // Case 4: MRET with pipe_clear low for 5 cycles
    mepc = 32'h4000; ret = 1'b1; pipe_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c4.drain_ret_we", {31'd0, ret_we}, 32'd0);
    end
    pipe_clear = 1'b1;
    tick();
    chk("c4.ret_we", {31'd0, ret_we}, 32'd1);
    chk("c4.trap_we", {31'd0, trap_we}, 32'd0);
    tick();
    chk("c4.insert_pc", {31'd0, insert_pc}, 32'd1);
    chk("c4.priv_pc", priv_pc, 32'h4000);
    chk("c4.intr", {31'd0, intr}, 32'd0);
    chk("c4.ret_once", {31'd0, ret_we}, 32'd0);
    clr_events(); tick();

    // Case 5: WFI sleep, wake on soft_int with global enable off, no trap
    mstatus_mie = 1'b0; mie_bits = 3'b010; wfi = 1'b1;
    tick();
    chk("c5.stall", {31'd0, wfi_stall}, 32'd1);
    wfi = 1'b0;
    tick(); tick();
    chk("c5.stall_held", {31'd0, wfi_stall}, 32'd1);
    soft_int = 1'b1;
    tick();
    chk("c5.wake", {31'd0, wfi_stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c5.no_trap", {30'd0, trap_we, insert_pc}, 32'd0);
    end
    clr_events(); tick();

    // Case 6: drain timeout after 16 DRAIN cycles
    pipe_clear = 1'b0; breakpoint = 1'b1; epc = 32'h400; badaddr = 32'h400;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("c6.drain", {30'd0, trap_we, drain_timeout}, 32'd0);
    end
    tick();
    chk("c6.timeout", {31'd0, drain_timeout}, 32'd1);
    chk("c6.trap_we", {31'd0, trap_we}, 32'd1);
    chk("c6.mcause", mcause_o, 32'd3);
    tick();
    chk("c6.insert_pc", {31'd0, insert_pc}, 32'd1);
    chk("c6.priv_pc", priv_pc, 32'h100);
    clr_events(); pipe_clear = 1'b1; tick();
    chk("c6.sticky", {31'd0, drain_timeout}, 32'd1);

    // Vector wrap modulo 2^32, and mode 11 treated as direct
    mtvec = 32'hFFFF_FFFD; mstatus_mie = 1'b1; mie_bits = 3'b100; ext_int = 1'b1; epc = 32'h500;
    do_trap("wrap", 32'h8000_000B, 32'h500, 32'h0, 32'h28, 1'b1);
    clr_events(); tick();
    mtvec = 32'h203; mie_bits = 3'b010; soft_int = 1'b1; epc = 32'h504;
    do_trap("mode11", 32'h8000_0003, 32'h504, 32'h0, 32'h200, 1'b1);
    clr_events(); tick();

    // Reset asserted during COMMIT abandons the trap
    env = 1'b1; epc = 32'h600;
    tick(); tick();
    chk("rstc.commit", {31'd0, trap_we}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("rstc.trap_we", {31'd0, trap_we}, 32'd0);
    chk("rstc.mcause", mcause_o, 32'd0);
    chk("rstc.mepc", mepc_o, 32'd0);
    chk("rstc.timeout", {31'd0, drain_timeout}, 32'd0);
    clr_events();
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstc.no_ins", {30'd0, insert_pc, trap_we}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
